karatsuba_multiplier: RTL and testbench
=======================================

KARATSUBA_MULTIPLIER -- requirements
Module: karatsuba_multiplier

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand width; only 16 is supported, and any other value is a configuration error.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port in_valid, input, 1 bit: qualifies a and b in the current cycle.
REQ-005 The module SHALL have port a, input, 16 bits: unsigned multiplicand.
REQ-006 The module SHALL have port b, input, 16 bits: unsigned multiplier.
REQ-007 The module SHALL have port out_valid, output, 1 bit: prod holds a valid result this cycle.
REQ-008 The module SHALL have port prod, output, 32 bits: unsigned product a*b.

Function
REQ-009 prod SHALL equal the exact unsigned product a*b, 32 bits wide, with no truncation or overflow for any operands, including 65535*65535 = 4294836225.
REQ-010 The product SHALL be computed by Karatsuba decomposition, not by a single `*` operator on 16-bit operands:
- split: aH=a[15:8], aL=a[7:0], bH=b[15:8], bL=b[7:0]
- z2 = aH*bH
- z0 = aL*bL
- z1 = (aH+aL)*(bH+bL) - z2 - z0
- prod = (z2<<16) + (z1<<8) + z0
REQ-011 The middle sums aH+aL and bH+bL SHALL be 9 bits wide, and their product 18 bits wide. z1 SHALL be held in at least 18 bits; it is never negative.
REQ-012 Each 8x8 and 9x9 sub-product SHALL itself use one further Karatsuba level on 4-bit and 5-bit halves. Base cases of 5x5 bits or smaller MAY use direct multiplication.
REQ-013 The pipeline SHALL have two register stages:
- stage 1 registers a, b and in_valid when a rising clock edge occurs
- stage 2 registers prod and out_valid from the stage-1 contents through the combinational Karatsuba network
REQ-014 Latency SHALL be exactly 2 clock edges: operands sampled at edge N with in_valid=1 appear on prod with out_valid=1 after edge N+1.
REQ-015 Throughput SHALL be one new operand pair per cycle, with no stalls and no backpressure.
REQ-016 out_valid SHALL be in_valid delayed by 2 cycles.
REQ-017 When in_valid=0, the stage-1 operand registers SHALL still load. prod SHALL show the product of whatever was loaded; consumers SHALL qualify prod with out_valid.
REQ-018 Operand zero SHALL give prod=0. The partial-sum carries (for example aH+aL=510) SHALL be handled without loss.

Reset
REQ-019 When rst_n=0, all pipeline registers SHALL clear immediately, independent of clk: prod=0, out_valid=0, and the stage-1 registers=0.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight results. After rst_n rises, out_valid SHALL stay 0 until 2 edges after the first in_valid=1 is sampled.
REQ-021 Reset release SHALL be synchronised externally; the block adds no reset synchroniser.

Verification
REQ-022 Small operands, one per cycle back-to-back:
- 3*5 -> 15
- 12*10 -> 120
- 8*7 -> 56
- 15*15 -> 225
- 0*1 -> 0
Each result SHALL appear 2 cycles after its operands, with out_valid=1.
REQ-023 Boundary operands:
- 65535*65535 -> 4294836225
- 32768*2 -> 65536
- 1024*1024 -> 1048576
- 1234*5678 -> 7006652
REQ-024 Reset behaviour: assert rst_n=0 asynchronously between clock edges while results are in flight -> prod=0 and out_valid=0 at once. Release and apply 3*5 -> 15 exactly 2 cycles later.
REQ-025 in_valid gaps: pattern 1,0,1 with operands 2*3, x, 4*5 -> out_valid pattern 1,0,1 two cycles later, carrying 6 and 20.
REQ-026 Random regression: at least 10000 random operand pairs, compared against a*b from a reference model, with a check for 2-cycle alignment.

Source files
------------

// File: rtl/karatsuba_multiplier.sv
// Two-stage pipelined 16x16 unsigned multiplier built from two levels of
// Karatsuba decomposition: 16 -> 8/9-bit sub-products -> 4/5-bit base cases.

// Second-level Karatsuba cell for N = 8 or 9 bit operands.
// The high half is N-4 bits (4 or 5) and the low half is 4 bits, so the
// half-sums are up to 6 bits. The 6x6 middle product is split on its top
// bit so that the only true multiplier stays 5x5.
module karatsuba_multiplier_sub #(
  parameter int N = 8
) (
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic [2*N-1:0] p
);
  localparam int H = N - 4;

  logic [H-1:0]     w_xh, w_yh;
  logic [3:0]       w_xl, w_yl;
  logic [5:0]       w_sx, w_sy;
  logic [2*H-1:0]   w_z2;
  logic [7:0]       w_z0;
  logic [9:0]       w_base;
  logic [11:0]      w_mid;
  logic [11:0]      w_z1;

  assign w_xh = x[N-1:4];
  assign w_yh = y[N-1:4];
  assign w_xl = x[3:0];
  assign w_yl = y[3:0];

  // Half-sums carry into bit 5 only when the high half is 5 bits wide.
  assign w_sx = 6'(w_xh) + 6'(w_xl);
  assign w_sy = 6'(w_yh) + 6'(w_yl);

  // Base cases: direct products of at most 5x5 bits.
  assign w_z2   = (2*H)'(w_xh) * (2*H)'(w_yh);
  assign w_z0   = 8'(w_xl) * 8'(w_yl);
  assign w_base = 10'(w_sx[4:0]) * 10'(w_sy[4:0]);

  // (32*cx + sx)(32*cy + sy) expanded; the carry terms are gated adds.
  assign w_mid = 12'(w_base)
               + (w_sx[5] ? 12'({w_sy[4:0], 5'b0}) : 12'd0)
               + (w_sy[5] ? 12'({w_sx[4:0], 5'b0}) : 12'd0)
               + ((w_sx[5] & w_sy[5]) ? 12'd1024 : 12'd0);

  // Cross term xh*yl + xl*yh, never negative.
  assign w_z1 = w_mid - 12'(w_z2) - 12'(w_z0);

  assign p = ((2*N)'(w_z2) << 8) + ((2*N)'(w_z1) << 4) + (2*N)'(w_z0);
endmodule

module karatsuba_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] prod
);
  // The datapath below is hand-split for 16-bit operands only.
  if (WIDTH != 16) begin : g_bad_width
    $error("karatsuba_multiplier: only WIDTH=16 is supported");
  end

  logic [15:0] r_a, r_b;
  logic [1:0]  r_vld_pipe;
  logic [31:0] r_prod;

  logic [7:0]  w_ah, w_al, w_bh, w_bl;
  logic [8:0]  w_sa, w_sb;
  logic [15:0] w_z2, w_z0;
  logic [17:0] w_m, w_z1;
  logic [31:0] w_prod;

  // Stage 1: operands load every cycle; in_valid enters the valid pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a           <= '0;
      r_b           <= '0;
      r_vld_pipe[0] <= 1'b0;
    end else begin
      r_a           <= a[15:0];
      r_b           <= b[15:0];
      r_vld_pipe[0] <= in_valid;
    end
  end

  assign w_ah = r_a[15:8];
  assign w_al = r_a[7:0];
  assign w_bh = r_b[15:8];
  assign w_bl = r_b[7:0];

  // 9-bit half-sums keep the carry (255+255 = 510).
  assign w_sa = {1'b0, w_ah} + {1'b0, w_al};
  assign w_sb = {1'b0, w_bh} + {1'b0, w_bl};

  karatsuba_multiplier_sub #(.N(8)) u_z2 (.x(w_ah), .y(w_bh), .p(w_z2));
  karatsuba_multiplier_sub #(.N(8)) u_z0 (.x(w_al), .y(w_bl), .p(w_z0));
  karatsuba_multiplier_sub #(.N(9)) u_zm (.x(w_sa), .y(w_sb), .p(w_m));

  // Cross term aH*bL + aL*bH; fits in 17 bits, held in 18.
  assign w_z1 = w_m - 18'(w_z2) - 18'(w_z0);

  assign w_prod = {w_z2, 16'b0} + (32'(w_z1) << 8) + 32'(w_z0);

  // Stage 2: registered product and delayed valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod        <= '0;
      r_vld_pipe[1] <= 1'b0;
    end else begin
      r_prod        <= w_prod;
      r_vld_pipe[1] <= r_vld_pipe[0];
    end
  end

  assign prod      = (2*WIDTH)'(r_prod);
  assign out_valid = r_vld_pipe[1];
endmodule

// File: tb/tb_karatsuba_multiplier.sv
// Scoreboard bench: stimulus pushes a*b with its due edge, monitor pops on out_valid.
module tb_karatsuba_multiplier;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        out_valid;
  logic [31:0] prod;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] p;
    int          due;
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;
  exp_t sbq[$];

  karatsuba_multiplier #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .out_valid(out_valid), .prod(prod)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge; the next rising edge samples it
  // and the result is due after the edge following that.
  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    a = x;
    b = y;
    if (v) begin
      e.p   = 32'(x) * 32'(y);
      e.due = cyc + 2;
      e.x   = x;
      e.y   = y;
      sbq.push_back(e);
    end
  endtask

  // Monitor: count edges, then sample 1 time unit later.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid: out_valid=1 at edge %0d with nothing expected", cyc);
      end else begin
        e = sbq.pop_front();
        total++;
        if (prod !== e.p || cyc != e.due) begin
          bad++;
          $display("FAIL product %0d*%0d: got %0d at edge %0d expected %0d at edge %0d",
                   e.x, e.y, prod, cyc, e.p, e.due);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL missing_valid %0d*%0d: out_valid=%b at edge %0d expected 1",
               e.x, e.y, out_valid, cyc);
    end
  end

  logic [15:0] small_a [5] = '{16'd3, 16'd12, 16'd8, 16'd15, 16'd0};
  logic [15:0] small_b [5] = '{16'd5, 16'd10, 16'd7, 16'd15, 16'd1};
  logic [15:0] bnd_a   [6] = '{16'd65535, 16'd32768, 16'd1024, 16'd1234, 16'd255, 16'd65535};
  logic [15:0] bnd_b   [6] = '{16'd65535, 16'd2, 16'd1024, 16'd5678, 16'd255, 16'd0};

  initial begin
    // Reset state at time 0, before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_prod", prod, 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Small operands back-to-back.
    for (int i = 0; i < 5; i++) drive(1'b1, small_a[i], small_b[i]);
    // Boundary operands back-to-back.
    for (int i = 0; i < 6; i++) drive(1'b1, bnd_a[i], bnd_b[i]);
    // in_valid gap pattern 1,0,1.
    drive(1'b1, 16'd2, 16'd3);
    drive(1'b0, 16'($urandom), 16'($urandom));
    drive(1'b1, 16'd4, 16'd5);
    drive(1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);

    // Asynchronous reset while results are in flight.
    drive(1'b1, 16'd100, 16'd200);
    drive(1'b1, 16'd300, 16'd400);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("async_reset_prod", prod, 32'd0);
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'd3, 16'd5);
    drive(1'b0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);

    // Random regression with random valid gaps.
    for (int n = 0; n < 10000; ) begin
      logic        v;
      logic [15:0] x, y;
      v = ($urandom_range(0, 7) != 0);
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 15) == 0) x = 16'hFFFF;
      if ($urandom_range(0, 15) == 0) y = 16'hFFFF;
      if ($urandom_range(0, 31) == 0) x = 16'h0000;
      drive(v, x, y);
      if (v) n++;
    end
    drive(1'b0, 16'd0, 16'd0);

    // Bounded drain of the scoreboard.
    repeat (4) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
